logic_gate_identifier: RTL and testbench
========================================

// Module: logic_gate_identifier
// PURPOSE
//   Sequential tester for a 2-input combinational gate: drives all four input vectors
//   onto the gate under test, samples its output, then classifies the truth table.
//   Output: AND/OR/NOT/NAND/NOR/XOR/XNOR or unknown.
//   Sits beside any 2-input gate block as its self-check/identification companion.
// PARAMETERS
//   SETTLE_CYCLES  2  wait cycles per vector before sampling y_in; legal range 1..15
// PORTS
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   start        in   1  level-sampled request; accepted only in IDLE
//   y_in         in   1  output of gate under test
//   a_out        out  1  input a driven to gate under test
//   b_out        out  1  input b driven to gate under test
//   busy         out  1  high from the cycle after start is accepted until done
//   done         out  1  one-cycle pulse; results valid
//   gate_id      out  3  0 AND,1 OR,2 NOT(a),3 NAND,4 NOR,5 XOR,6 XNOR,7 unknown
//   id_valid     out  1  1 when gate_id != 7
//   truth_table  out  4  bit i = sampled y for {a,b}=i (a=i[1], b=i[0])
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=IDLE, vector index=0, wait counter=0.
//   - FSM states:
//     - IDLE: start=1 at edge E0 -> DRIVE; index=0; a_out/b_out=00; busy=1.
//     - DRIVE: holds {a_out,b_out}=index for SETTLE_CYCLES+1 cycles.
//       y_in captured into tt[index] on the last edge of the window.
//       index<3: index++ and stay in DRIVE; index==3: go to DECODE.
//     - DECODE: one cycle; compare tt against table:
//       1000 AND, 1110 OR, 0011 NOT, 0111 NAND, 0001 NOR, 0110 XOR, 1001 XNOR, else 7.
//     - DONE: one cycle; done=1, busy=0, results registered; then IDLE.
//   - Timing (S=SETTLE_CYCLES):
//     - sample edges E0+k*(S+1), k=1..4;
//     - done high during the cycle after edge E0+4(S+1)+2 (S=2: samples at 3,6,9,12; done after edge 14).
//   - a_out/b_out return to 00 in DECODE/DONE/IDLE.
//   - gate_id/id_valid/truth_table update only on entry to DONE; held until next DONE.
//   - start while busy or in DECODE/DONE: ignored (no queueing).
//   - start held high: a new run begins in IDLE on the cycle after DONE.
//   - rst_n low mid-run: immediate return to reset values; partial samples discarded.
//   - Wait counter width: clog2(S+4); wraps to 0 at each vector boundary.
// CONFIGURATION
//   LOGIC_GATE_ID_SYNC_EN defined:
//     - y_in passes through a 2-flop synchronizer (reset 0);
//     - each vector window lengthens to S+3 cycles so sampling sees the settled, synchronized value;
//     - samples at E0+k*(S+3); S=2: done after edge 22.
//   Not defined: y_in sampled directly; timing as above.
// TESTING
//   1 AND model on y_in, S=2, start 1 cycle:
//     a/b sequence 00,01,10,11 (3 cycles each); done after edge 14.
//     gate_id=0, tt=1000, id_valid=1.
//   2 Sweep XOR, XNOR, NOT(a), NOR:
//     gate_id 5/6/2/4; tt 0110/1001/0011/0001.
//   3 y_in tied 1: tt=1111, gate_id=7, id_valid=0, done still pulses.
//   4 rst_n low 5 cycles into a run:
//     all outputs 0 immediately; no done;
//     fresh start on NAND model -> gate_id=3 after normal latency.
//   5 start re-pulsed at cycles 4 and 8 of a run: ignored; exactly one done pulse.
//   6 LOGIC_GATE_ID_SYNC_EN, OR model:
//     done after edge 22, gate_id=1, tt=1110.

Source files
------------

// File: rtl/logic_gate_identifier_if.sv
// Request/result bundle between a controller and the logic_gate_identifier tester.
// The gate under test sits on y_in (from the gate) and a_out/b_out (to the gate).
interface logic_gate_identifier_if;
    logic       start;
    logic       y_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic [2:0] gate_id;
    logic       id_valid;
    logic [3:0] truth_table;

    modport master (
        output start, y_in,
        input  a_out, b_out, busy, done, gate_id, id_valid, truth_table
    );

    modport slave (
        input  start, y_in,
        output a_out, b_out, busy, done, gate_id, id_valid, truth_table
    );
endinterface

// File: rtl/logic_gate_identifier.sv
// Drives all four {a,b} vectors onto a 2-input gate, samples y_in and classifies the truth table.
// Optional LOGIC_GATE_ID_SYNC_EN: 2-flop y_in synchronizer with a window lengthened by two cycles.
module logic_gate_identifier #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    logic_gate_identifier_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 4);
`ifdef LOGIC_GATE_ID_SYNC_EN
    localparam int unsigned WIN_LAST = SETTLE_CYCLES + 2;
`else
    localparam int unsigned WIN_LAST = SETTLE_CYCLES;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_q,       state_d;
    logic [1:0]       idx_q,         idx_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [3:0]       tt_q,          tt_d;
    logic [2:0]       id_dec_q,      id_dec_d;
    logic             a_q,           a_d;
    logic             b_q,           b_d;
    logic             busy_q,        busy_d;
    logic             done_q,        done_d;
    logic [2:0]       gate_id_q,     gate_id_d;
    logic             id_valid_q,    id_valid_d;
    logic [3:0]       truth_tbl_q,   truth_tbl_d;
    logic             y_s;

`ifdef LOGIC_GATE_ID_SYNC_EN
    logic y_meta_q, y_sync_q;

    // Two-stage synchronizer for an asynchronous gate output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_meta_q <= 1'b0;
            y_sync_q <= 1'b0;
        end else begin
            y_meta_q <= bus.y_in;
            y_sync_q <= y_meta_q;
        end
    end
    assign y_s = y_sync_q;
`else
    assign y_s = bus.y_in;
`endif

    function automatic logic [2:0] decode_tt(input logic [3:0] tt);
        case (tt)
            4'b1000: decode_tt = 3'd0;
            4'b1110: decode_tt = 3'd1;
            4'b0011: decode_tt = 3'd2;
            4'b0111: decode_tt = 3'd3;
            4'b0001: decode_tt = 3'd4;
            4'b0110: decode_tt = 3'd5;
            4'b1001: decode_tt = 3'd6;
            default: decode_tt = 3'd7;
        endcase
    endfunction

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tt_d        = tt_q;
        id_dec_d    = id_dec_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        gate_id_d   = gate_id_q;
        id_valid_d  = id_valid_q;
        truth_tbl_d = truth_tbl_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    tt_d    = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(WIN_LAST)) begin
                    // Last edge of the window: capture and advance to the next vector
                    cnt_d       = '0;
                    tt_d[idx_q] = y_s;
                    if (idx_q == 2'd3) begin
                        state_d = ST_DECODE;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        {a_d, b_d} = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                id_dec_d = decode_tt(tt_q);
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                gate_id_d   = id_dec_q;
                id_valid_d  = (id_dec_q != 3'd7);
                truth_tbl_d = tt_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                idx_d       = 2'd0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            tt_q        <= 4'd0;
            id_dec_q    <= 3'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gate_id_q   <= 3'd0;
            id_valid_q  <= 1'b0;
            truth_tbl_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tt_q        <= tt_d;
            id_dec_q    <= id_dec_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gate_id_q   <= gate_id_d;
            id_valid_q  <= id_valid_d;
            truth_tbl_q <= truth_tbl_d;
        end
    end

    assign bus.a_out       = a_q;
    assign bus.b_out       = b_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.gate_id     = gate_id_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.truth_table = truth_tbl_q;

endmodule

// File: tb/tb_logic_gate_identifier.sv
// Randomized self-checking bench for logic_gate_identifier; a gate model drives y_in from a_out/b_out.
// Build with +define+LOGIC_GATE_ID_SYNC_EN to exercise the synchronized-window timing.
module tb_logic_gate_identifier;

    localparam int S = 2;
`ifdef LOGIC_GATE_ID_SYNC_EN
    localparam int W = S + 3;
`else
    localparam int W = S + 1;
`endif
    localparam int L = 4 * W + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   gate_sel = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_gate_identifier_if bus();

    logic_gate_identifier #(.SETTLE_CYCLES(S)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Gate models: 0..6 are the recognised gates, 7..11 are not
    function automatic logic model_y(input int sel, input logic a, input logic b);
        case (sel)
            0:  model_y = a & b;
            1:  model_y = a | b;
            2:  model_y = ~a;
            3:  model_y = ~(a & b);
            4:  model_y = ~(a | b);
            5:  model_y = a ^ b;
            6:  model_y = ~(a ^ b);
            7:  model_y = 1'b1;
            8:  model_y = 1'b0;
            9:  model_y = b;
            10: model_y = ~b;
            default: model_y = a;
        endcase
    endfunction

    always_comb bus.y_in = model_y(gate_sel, bus.a_out, bus.b_out);

    function automatic logic [3:0] ref_table(input int sel);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) t[i] = model_y(sel, 1'(i / 2), 1'(i % 2));
        return t;
    endfunction

    function automatic logic [2:0] ref_id(input logic [3:0] tt);
        logic [3:0] known [7];
        known = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
        for (int k = 0; k < 7; k++) if (known[k] == tt) return 3'(k);
        return 3'd7;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({bus.a_out, bus.b_out, bus.busy, bus.done, bus.gate_id, bus.id_valid, bus.truth_table} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {bus.a_out, bus.b_out, bus.busy, bus.done, bus.gate_id, bus.id_valid, bus.truth_table});
        end
        rst_n = 1'b1;
    endtask

    // One full identification run with per-cycle checks of a/b, busy, done and results
    task automatic test_gate_run(input int sel, input bit repulse);
        logic [3:0] exp_tt;
        logic [2:0] exp_id;
        logic [1:0] exp_ab;
        exp_tt   = ref_table(sel);
        exp_id   = ref_id(exp_tt);
        gate_sel = sel;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n <= L + 3; n++) begin
            exp_ab = (n < 4 * W) ? 2'(n / W) : 2'b00;
            n_checks++;
            if ({bus.a_out, bus.b_out} !== exp_ab) begin
                n_fail++;
                $display("FAIL ab_seq sel=%0d n=%0d: got %b want %b", sel, n, {bus.a_out, bus.b_out}, exp_ab);
            end
            n_checks++;
            if (bus.busy !== (n < L)) begin
                n_fail++;
                $display("FAIL busy sel=%0d n=%0d: got %b want %b", sel, n, bus.busy, (n < L));
            end
            n_checks++;
            if (bus.done !== (n == L)) begin
                n_fail++;
                $display("FAIL done sel=%0d n=%0d: got %b want %b", sel, n, bus.done, (n == L));
            end
            if (n >= L) begin
                n_checks++;
                if (bus.truth_table !== exp_tt || bus.gate_id !== exp_id || bus.id_valid !== (exp_id != 3'd7)) begin
                    n_fail++;
                    $display("FAIL result sel=%0d n=%0d: got tt=%b id=%0d v=%b want tt=%b id=%0d v=%b",
                             sel, n, bus.truth_table, bus.gate_id, bus.id_valid,
                             exp_tt, exp_id, (exp_id != 3'd7));
                end
            end
            bus.start = (repulse && (n == 3 || n == 7)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_gate_sweep;
        int fixed [6] = '{0, 5, 6, 2, 4, 7};
        foreach (fixed[i]) test_gate_run(fixed[i], 1'b0);
        for (int i = 0; i < 8; i++) test_gate_run(int'($urandom_range(0, 11)), 1'b0);
    endtask

    task automatic test_reset_mid_run;
        gate_sel = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.a_out, bus.b_out, bus.busy, bus.done, bus.gate_id, bus.id_valid, bus.truth_table} !== 12'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b want all zero",
                     {bus.a_out, bus.b_out, bus.busy, bus.done, bus.gate_id, bus.id_valid, bus.truth_table});
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < L + 4; n++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle n=%0d: got done=%b busy=%b want 0 0", n, bus.done, bus.busy);
            end
        end
        test_gate_run(3, 1'b0);
    endtask

    task automatic test_start_ignored;
        test_gate_run(1, 1'b1);
    endtask

    // start held high: second run accepted on the cycle after the done pulse
    task automatic test_back_to_back;
        int done_cyc [$];
        gate_sel = 5;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 0; n < 3 * L && done_cyc.size() < 2; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cyc.push_back(cyc);
                if (done_cyc.size() == 2) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (done_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d pulses want 2", done_cyc.size());
        end else begin
            n_checks++;
            if (done_cyc[1] - done_cyc[0] != L + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles want %0d", done_cyc[1] - done_cyc[0], L + 1);
            end
            n_checks++;
            if (bus.gate_id !== 3'd5 || bus.truth_table !== 4'b0110) begin
                n_fail++;
                $display("FAIL b2b_result: got id=%0d tt=%b want 5 0110", bus.gate_id, bus.truth_table);
            end
        end
        repeat (L + 2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_gate_sweep();
        test_reset_mid_run();
        test_start_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
